// File: rtl/nrisc_mc_if.sv
// Fetch and data-memory handshake bundle for the nrisc_mc multi-cycle core.
// master = core side, slave = memory side.
interface nrisc_mc_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ready;
  logic [7:0]        imem_rdata;
  logic              dmem_req;
  logic              dmem_we;
  logic [ADDR_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic              dmem_ready;
  logic [DATA_W-1:0] dmem_rdata;

  modport master (
    output imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  imem_ready, imem_rdata, dmem_ready, dmem_rdata
  );
  modport slave (
    input  imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output imem_ready, imem_rdata, dmem_ready, dmem_rdata
  );
endinterface

// File: rtl/nrisc_mc.sv
// Tiny 8-bit-instruction multi-cycle RISC core: FETCH/DECODE/EXEC/MEM/WB,
// four general registers, ready-handshaked instruction and data memories.
module nrisc_mc #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  nrisc_mc_if.master        bus,
  output logic              retired,
  output logic [ADDR_W-1:0] pc_out
);
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB} state_t;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_NAND = 3'd2;
  localparam logic [2:0] OP_LI   = 3'd3;
  localparam logic [2:0] OP_LD   = 3'd4;
  localparam logic [2:0] OP_ST   = 3'd5;
  localparam logic [2:0] OP_BEQZ = 3'd6;

  state_t                  state, state_nxt;
  logic                    run;
  logic [ADDR_W-1:0]       pc, maddr, pc_inc, br_off;
  logic [7:0]              ir;
  logic [3:0][DATA_W-1:0]  rf;
  logic [DATA_W-1:0]       a, b, res;
  logic [2:0]              op;
  logic [1:0]              rd, rs;
  logic                    is_mem, is_ctl;

  assign op     = ir[7:5];
  assign rd     = ir[4:3];
  assign rs     = ir[2:1];
  assign is_mem = (op == OP_LD) || (op == OP_ST);
  assign is_ctl = op[2] & op[1];
  assign pc_inc = pc + ADDR_W'(1);
  assign br_off = {{(ADDR_W-3){ir[2]}}, ir[2:0]};
  assign pc_out = pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FETCH;
    else        state <= state_nxt;
  end

  // run holds fetch off until the first edge after reset release
  always_comb begin
    state_nxt      = state;
    bus.imem_req   = 1'b0;
    bus.dmem_req   = 1'b0;
    bus.dmem_we    = 1'b0;
    retired        = 1'b0;
    bus.imem_addr  = pc;
    bus.dmem_addr  = maddr;
    bus.dmem_wdata = a;
    case (state)
      FETCH: begin
        bus.imem_req = run;
        if (run && bus.imem_ready) state_nxt = DECODE;
      end
      DECODE: state_nxt = EXEC;
      EXEC: begin
        if (is_mem)      state_nxt = MEM;
        else if (is_ctl) begin state_nxt = FETCH; retired = 1'b1; end
        else             state_nxt = WB;
      end
      MEM: begin
        bus.dmem_req = 1'b1;
        bus.dmem_we  = (op == OP_ST);
        if (bus.dmem_ready) begin
          state_nxt = (op == OP_ST) ? FETCH : WB;
          retired   = (op == OP_ST);
        end
      end
      WB: begin
        state_nxt = FETCH;
        retired   = 1'b1;
      end
      default: state_nxt = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run   <= 1'b0;
      pc    <= '0;
      ir    <= '0;
      rf    <= '0;
      a     <= '0;
      b     <= '0;
      res   <= '0;
      maddr <= '0;
    end else begin
      run <= 1'b1;
      case (state)
        FETCH:  if (run && bus.imem_ready) ir <= bus.imem_rdata;
        DECODE: begin
          a <= rf[rd];
          b <= rf[rs];
        end
        EXEC: begin
          case (op)
            OP_ADD:       res   <= a + b;
            OP_SUB:       res   <= a - b;
            OP_NAND:      res   <= ~(a & b);
            OP_LI:        res   <= DATA_W'(ir[2:0]);
            OP_LD, OP_ST: maddr <= ADDR_W'(b);
            OP_BEQZ:      pc    <= (a == '0) ? pc_inc + br_off : pc_inc;
            default:      pc    <= ADDR_W'(a);
          endcase
        end
        MEM: begin
          if (bus.dmem_ready) begin
            if (op == OP_ST) pc  <= pc_inc;
            else             res <= bus.dmem_rdata;
          end
        end
        WB: begin
          rf[rd] <= res;
          pc     <= pc_inc;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_nrisc_mc.sv
// Bench for nrisc_mc: an 8-bit and a 16-bit core run the same programs against an
// instruction-level model (register/memory arrays stepped once per retirement).
module tb_nrisc_mc;
  localparam int AW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic [7:0]  imem    [256];
  logic [31:0] dm_init [256];
  int wait_pct = 0;
  bit noise = 1'b0;
  int dhold = 0;
  int n0, n1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : gen
    localparam int DW = 8 * (g + 1);
    localparam logic [31:0] M = (32'd1 << DW) - 32'd1;

    nrisc_mc_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
    logic          retired;
    logic [AW-1:0] pc_out;

    nrisc_mc #(.DATA_W(DW), .ADDR_W(AW)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus), .retired(retired), .pc_out(pc_out)
    );

    logic [31:0]   r  [4];
    logic [31:0]   dm [256];
    logic [AW-1:0] mpc, ea, nxt, p_iaddr, p_daddr;
    logic [7:0]    ins;
    logic [DW-1:0] p_wd;
    logic          p_we;
    bit act, p_ireq, p_irdy, p_dreq, p_drdy;
    int cyc, waits, base, dleft;
    int ret_cnt = 0, wr_cnt = 0, dreq_cyc = 0, last_lat = 0;
    logic [31:0] last_wd = '0, last_wa = '0;

    initial begin
      bus.imem_ready = 1'b0; bus.imem_rdata = '0;
      bus.dmem_ready = 1'b0; bus.dmem_rdata = '0;
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          act = 0; cyc = 0; waits = 0; dleft = 0; mpc = '0;
          p_ireq = 0; p_irdy = 0; p_dreq = 0; p_drdy = 0;
          for (int i = 0; i < 4; i++) r[i] = '0;
          for (int i = 0; i < 256; i++) dm[i] = dm_init[i] & M;
          bus.imem_ready = 1'b0; bus.dmem_ready = 1'b0;
        end else begin
          bus.imem_rdata = imem[bus.imem_addr];
          bus.imem_ready = bus.imem_req ? ($urandom_range(99) >= 32'(wait_pct))
                                        : (noise && ($urandom_range(1) == 1));
          if (bus.dmem_req && !p_dreq) dleft = dhold;
          if (bus.dmem_req && dleft > 0) begin
            bus.dmem_ready = 1'b0;
            dleft--;
          end else begin
            bus.dmem_ready = bus.dmem_req ? ($urandom_range(99) >= 32'(wait_pct))
                                          : (noise && ($urandom_range(1) == 1));
          end
          bus.dmem_rdata = DW'(dm[bus.dmem_addr]);
          #1;
          chk($sformatf("excl%0d", g), 32'(bus.imem_req & bus.dmem_req), 0);
          if (p_ireq && !p_irdy && bus.imem_req)
            chk($sformatf("i_stable%0d", g), 32'(bus.imem_addr), 32'(p_iaddr));
          if (p_dreq && !p_drdy && bus.dmem_req)
            chk($sformatf("d_stable%0d", g), 32'({bus.dmem_we, bus.dmem_addr, bus.dmem_wdata}),
                32'({p_we, p_daddr, p_wd}));
          if (p_ireq && p_irdy) chk($sformatf("i_drop%0d", g), 32'(bus.imem_req), 0);
          if (p_dreq && p_drdy) chk($sformatf("d_drop%0d", g), 32'(bus.dmem_req), 0);
          if (bus.imem_req && bus.imem_ready)
            chk($sformatf("fetch_pc%0d", g), 32'(bus.imem_addr), 32'(mpc));
          if (bus.imem_req) act = 1;
          if (act) begin
            cyc++;
            if ((bus.imem_req && !bus.imem_ready) || (bus.dmem_req && !bus.dmem_ready)) waits++;
          end
          if (bus.dmem_req) dreq_cyc++;
          if (bus.dmem_req && bus.dmem_ready && bus.dmem_we) begin
            wr_cnt++;
            last_wa = 32'(bus.dmem_addr);
            last_wd = 32'(bus.dmem_wdata);
          end
          if (retired) begin
            ins = imem[mpc];
            ea  = r[ins[2:1]][AW-1:0];
            nxt = mpc + 8'd1;
            base = 4;
            case (ins[7:5])
              3'd0: r[ins[4:3]] = (r[ins[4:3]] + r[ins[2:1]]) & M;
              3'd1: r[ins[4:3]] = (r[ins[4:3]] - r[ins[2:1]]) & M;
              3'd2: r[ins[4:3]] = ~(r[ins[4:3]] & r[ins[2:1]]) & M;
              3'd3: r[ins[4:3]] = 32'(ins[2:0]);
              3'd4: begin base = 5; r[ins[4:3]] = dm[ea]; end
              3'd5: begin
                chk($sformatf("st_hs%0d", g), 32'(bus.dmem_req & bus.dmem_ready & bus.dmem_we), 1);
                chk($sformatf("st_addr%0d", g), 32'(bus.dmem_addr), 32'(ea));
                chk($sformatf("st_data%0d", g), 32'(bus.dmem_wdata), r[ins[4:3]]);
                dm[ea] = r[ins[4:3]];
              end
              3'd6: begin
                base = 3;
                if (r[ins[4:3]] == 0) nxt = mpc + 8'd1 + {{5{ins[2]}}, ins[2:0]};
              end
              default: begin base = 3; nxt = r[ins[4:3]][AW-1:0]; end
            endcase
            chk($sformatf("lat%0d_op%0d", g, ins[7:5]), cyc, base + waits);
            last_lat = cyc;
            mpc = nxt;
            ret_cnt++;
            cyc = 0;
            waits = 0;
          end
          p_ireq = bus.imem_req; p_irdy = bus.imem_ready; p_iaddr = bus.imem_addr;
          p_dreq = bus.dmem_req; p_drdy = bus.dmem_ready; p_daddr = bus.dmem_addr;
          p_wd = bus.dmem_wdata; p_we = bus.dmem_we;
        end
      end
    end
  end

  task automatic reset_on();
    rst_n = 1'b0;
    for (int i = 0; i < 256; i++) begin imem[i] = 8'hE0; dm_init[i] = '0; end
    @(negedge clk);
  endtask

  task automatic release_rst();
    @(negedge clk);
    #2 rst_n = 1'b1;
    n0 = gen[0].ret_cnt;
    n1 = gen[1].ret_cnt;
  endtask

  task automatic wait_ret(input int k0, input int k1, input int lim, input string tag);
    int k = 0;
    while ((gen[0].ret_cnt < k0 || gen[1].ret_cnt < k1) && k < lim) begin
      @(negedge clk); #2; k++;
    end
    chk({tag, "_timeout"}, 32'(k < lim), 1);
  endtask

  task automatic next_cyc();
    @(negedge clk); #2;
  endtask

  initial begin
    int k, w0, d0;
    // LI R1,5; LI R2,3; SUB R1,R2; ST R1,[R0]
    reset_on();
    imem[0] = 8'h6D; imem[1] = 8'h73; imem[2] = 8'h2C; imem[3] = 8'hA8;
    #3;
    chk("rst_ireq", 32'(gen[0].bus.imem_req), 0);
    chk("rst_dreq", 32'(gen[0].bus.dmem_req), 0);
    chk("rst_we", 32'(gen[1].bus.dmem_we), 0);
    chk("rst_ret", 32'(gen[1].retired), 0);
    chk("rst_pc", 32'(gen[0].pc_out), 0);
    chk("rst_daddr", 32'(gen[1].bus.dmem_addr), 0);
    chk("rst_wdata", 32'(gen[1].bus.dmem_wdata), 0);
    release_rst();
    for (int c = 1; c <= 12; c++) begin
      next_cyc();
      if (c == 1) begin
        chk("rel_ireq", 32'(gen[0].bus.imem_req), 1);
        chk("rel_iaddr", 32'(gen[0].bus.imem_addr), 0);
      end
      chk($sformatf("ret_cyc%0d", c), 32'(gen[0].retired), 32'((c % 4) == 0));
    end
    next_cyc();
    chk("prog_a_pc", 32'(gen[0].pc_out), 3);
    wait_ret(n0 + 4, n1 + 4, 100, "prog_a");
    chk("sub_r1_8", gen[0].last_wd, 2);
    chk("sub_r1_16", gen[1].last_wd, 2);

    // LI R2,1; LD R1,[R2] (=0xFF); ADD R1,R2; ST R1,[R0]
    reset_on();
    imem[0] = 8'h71; imem[1] = 8'h8C; imem[2] = 8'h0C; imem[3] = 8'hA8;
    dm_init[1] = 32'hFF;
    release_rst();
    wait_ret(n0 + 4, n1 + 4, 100, "prog_b");
    chk("add_wrap8", gen[0].last_wd, 32'h00);
    chk("add_16", gen[1].last_wd, 32'h100);

    // BEQZ R0,-2 at 0 -> 0xFF; LI R0,1 at 0xFF; BEQZ again at 0 -> 1
    reset_on();
    imem[0] = 8'hC6; imem[255] = 8'h61;
    release_rst();
    wait_ret(n0 + 1, n1 + 1, 100, "beqz_t");
    chk("beqz_lat", 32'(gen[0].last_lat), 3);
    next_cyc();
    chk("beqz_taken8", 32'(gen[0].pc_out), 32'hFF);
    chk("beqz_taken16", 32'(gen[1].pc_out), 32'hFF);
    wait_ret(n0 + 3, n1 + 3, 100, "beqz_nt");
    next_cyc();
    chk("beqz_not_taken", 32'(gen[0].pc_out), 1);

    // LI R3,2; LD R2,[R3] (=0x1A7); J R2
    reset_on();
    imem[0] = 8'h7A; imem[1] = 8'h96; imem[2] = 8'hF0;
    dm_init[2] = 32'h1A7;
    release_rst();
    wait_ret(n0 + 3, n1 + 3, 100, "jump");
    chk("j_lat16", 32'(gen[1].last_lat), 3);
    next_cyc();
    chk("j_pc16", 32'(gen[1].pc_out), 32'hA7);
    chk("j_pc8", 32'(gen[0].pc_out), 32'hA7);

    // LI R3,5; ST R3,[R3] with three data wait cycles
    reset_on();
    imem[0] = 8'h7D; imem[1] = 8'hBE;
    dhold = 3;
    release_rst();
    wait_ret(n0 + 1, n1 + 1, 100, "st_li");
    w0 = gen[0].wr_cnt;
    d0 = gen[0].dreq_cyc;
    wait_ret(n0 + 2, n1 + 2, 100, "st_wait");
    chk("st_wait_lat", 32'(gen[0].last_lat), 7);
    chk("st_one_write", 32'(gen[0].wr_cnt - w0), 1);
    chk("st_req_cycles", 32'(gen[0].dreq_cyc - d0), 4);
    chk("st_wait_data", gen[0].last_wd, 5);
    chk("st_wait_addr", gen[0].last_wa, 5);

    // LI R1,7; LD R1,[R0] stalled in MEM, then reset
    reset_on();
    imem[0] = 8'h6F; imem[1] = 8'h88;
    dm_init[0] = 32'h3C;
    dhold = 50;
    release_rst();
    k = 0;
    while (!gen[0].bus.dmem_req && k < 100) begin next_cyc(); k++; end
    chk("ld_mem_reached", 32'(k < 100), 1);
    w0 = gen[0].ret_cnt;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_dreq8", 32'(gen[0].bus.dmem_req), 0);
    chk("rst_mid_dreq16", 32'(gen[1].bus.dmem_req), 0);
    chk("rst_mid_ret", 32'(gen[0].retired), 0);
    chk("rst_mid_noret", 32'(gen[0].ret_cnt - w0), 0);
    dhold = 0;
    @(negedge clk);
    imem[0] = 8'hA8;
    release_rst();
    next_cyc();
    chk("rst_rel_ireq", 32'(gen[0].bus.imem_req), 1);
    chk("rst_rel_iaddr", 32'(gen[0].bus.imem_addr), 0);
    wait_ret(n0 + 1, n1 + 1, 100, "post_rst");
    chk("post_rst_r1", gen[0].last_wd, 0);

    // random programs, data and handshake timing
    reset_on();
    for (int i = 0; i < 256; i++) begin
      imem[i] = 8'($urandom);
      dm_init[i] = $urandom;
    end
    wait_pct = 30;
    noise = 1'b1;
    release_rst();
    wait_ret(n0 + 300, n1 + 300, 20000, "random");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/nrisc_mc.md
NRISC_MC -- requirements
Module: nrisc_mc

Interface
REQ-001 Parameter DATA_W, default 8, register and data-path width in bits; legal range 8..32.
REQ-002 Parameter ADDR_W, default 8, PC and memory address width in bits; legal range 4..16.
REQ-003 Clock  input  1  sole clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low; clears all state immediately when low.
REQ-005 imem_req  output  1  instruction fetch request.
REQ-006 imem_addr  output  ADDR_W  fetch address, equal to PC.
REQ-007 imem_ready  input  1  fetch data valid this cycle.
REQ-008 imem_rdata  input  8  instruction byte.
REQ-009 dmem_req  output  1  data memory request.
REQ-010 dmem_we  output  1  1 = store, 0 = load; meaningful only while dmem_req is high.
REQ-011 dmem_addr  output  ADDR_W  data address.
REQ-012 dmem_wdata  output  DATA_W  store data.
REQ-013 dmem_ready  input  1  data transaction complete this cycle.
REQ-014 dmem_rdata  input  DATA_W  load data, valid when dmem_ready is high.
REQ-015 retired  output  1  one-cycle pulse in the final cycle of each instruction.
REQ-016 pc_out  output  ADDR_W  current PC, for debug.

Function
REQ-017 The register file SHALL hold 4 registers R0..R3 of DATA_W bits; all are writable, and none is hardwired to zero.
REQ-018 Instruction fields SHALL be decoded as opcode=[7:5], rd=[4:3], rs=[2:1], imm3=[2:0].
REQ-019 Opcode 000 is ADD: rd<=rd+rs; 001 is SUB: rd<=rd-rs; 010 is NAND: rd<=~(rd&rs). Results SHALL wrap modulo 2^DATA_W.
REQ-020 Opcode 011 is LI: rd<=zero-extended imm3.
REQ-021 Opcode 100 is LD: rd<=mem[rs]. Opcode 101 is ST: mem[rs]<=rd. The address SHALL be rs truncated or zero-extended to ADDR_W.
REQ-022 Opcode 110 is BEQZ: if rd==0, PC<=PC+1+sext(imm3); otherwise PC<=PC+1.
REQ-023 Opcode 111 is J: PC<=rd truncated or zero-extended to ADDR_W.
REQ-024 All other instructions SHALL set PC<=PC+1. All PC arithmetic SHALL wrap modulo 2^ADDR_W.
REQ-025 The FSM SHALL have states FETCH, DECODE, EXEC, MEM, WB.
REQ-026 FETCH: imem_req=1. On imem_ready=1, latch IR and go to DECODE; otherwise stay in FETCH.
REQ-027 DECODE: latch operands A=R[rd] and B=R[rs]; go to EXEC.
REQ-028 EXEC, ALU or LI: latch the result and go to WB.
REQ-029 EXEC, LD or ST: latch the address and go to MEM.
REQ-030 EXEC, BEQZ, J or other: update PC, pulse retired, and go to FETCH.
REQ-031 MEM: dmem_req=1, with dmem_we=1 for ST. On dmem_ready=1: LD latches dmem_rdata and goes to WB; ST updates PC, pulses retired, and goes to FETCH.
REQ-032 WB: write rd, set PC<=PC+1, pulse retired, go to FETCH.
REQ-033 Minimum latency with zero-wait memory SHALL be: BEQZ/J/other 3 cycles; ALU, LI and ST 4 cycles; LD 5 cycles.
REQ-034 Each wait cycle (ready=0) SHALL add exactly one cycle of latency.
REQ-035 imem_addr, dmem_addr, dmem_we and dmem_wdata SHALL remain stable while the corresponding req is high.
REQ-036 Each req SHALL deassert in the cycle after ready is sampled high.
REQ-037 ready=1 in the first req cycle SHALL complete the transaction in that cycle.
REQ-038 ready inputs SHALL be ignored while the corresponding req is low.
REQ-039 dmem_req and imem_req SHALL never be high in the same cycle.
REQ-040 The register file SHALL be written only in WB, and only one register per instruction.

Reset
REQ-041 While reset=0, the block SHALL hold: PC=0, R0..R3=0, IR=0, state=FETCH, imem_req=0, dmem_req=0, dmem_we=0, retired=0; all other outputs 0.
REQ-042 Assertion of reset mid-transaction SHALL immediately drop every req and abandon the instruction, with no register write and no PC update.
REQ-043 After reset deasserts, the first rising edge SHALL begin FETCH at address 0, with imem_req=1 in that cycle.

Verification
REQ-044 Zero-wait memory; program LI R1,5; LI R2,3; SUB R1,R2 -> R1=2; retired pulses at cycles 4, 8 and 12; pc_out=3.
REQ-045 DATA_W=8; R1=0xFF, R2=0x01; ADD R1,R2 -> R1=0x00 (wrap); second run with DATA_W=16 -> R1=0x0100.
REQ-046 BEQZ R0 with imm3=3'b110 (offset -2) at PC=0 -> PC=0xFF for ADDR_W=8. Same instruction with R0=1 -> PC=1.
REQ-047 dmem_ready held 0 for 3 cycles during ST R3 -> dmem_req, dmem_addr and dmem_wdata stay stable for 4 cycles; instruction latency 7; exactly one write occurs.
REQ-048 reset pulled low during LD in MEM -> dmem_req=0 in the same cycle; rd unchanged; after release, imem_addr=0 and imem_req=1.
REQ-049 J R2 with R2=0x1A7, DATA_W=16, ADDR_W=8 -> PC=0xA7; latency 3 cycles.
